// File: rtl/riscv_mini_issue_ctrl.sv
// Byte-stream instruction assembler feeding a 4-entry issue FIFO, with result capture and issue counting.
// Optional macro ISSUE_BRANCH_FLUSH_EN: a taken branch at pop flushes the FIFO and the byte assembler.
module riscv_mini_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] issue_instr,
    output logic        issue_valid,
    input  logic        issue_ready,
    input  logic [7:0]  core_result,
    output logic [7:0]  result_out,
    output logic        result_valid,
    output logic [2:0]  fifo_count,
    output logic [7:0]  issued_count
);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } asm_state_t;

    localparam int DEPTH = 4;

    asm_state_t  state_reg;
    logic [7:0]  low_byte_reg;
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  count_reg;
    logic [7:0]  issued_reg;
    logic [7:0]  result_reg;
    logic        result_valid_reg;
    logic [15:0] entry_reg [DEPTH];

    logic byte_accept;
    logic push;
    logic pop;

    // Handshakes depend only on registered occupancy (and reset), never on issue_ready.
    assign in_ready    = !rst && (count_reg != 3'd4);
    assign issue_valid = !rst && (count_reg != 3'd0);
    assign issue_instr = entry_reg[rd_ptr_reg];

    assign byte_accept = in_valid && in_ready;
    assign push        = byte_accept && (state_reg == HIGH);
    assign pop         = issue_valid && issue_ready;

`ifdef ISSUE_BRANCH_FLUSH_EN
    logic is_branch;
    logic flush;

    assign is_branch = (issue_instr[1:0] == 2'b11) &&
                       ((issue_instr[13:11] == 3'b010) || (issue_instr[13:11] == 3'b011));
    assign flush     = pop && is_branch && core_result[0];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 2'(gi))) begin
                    entry_reg[gi] <= {in_byte, low_byte_reg};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= LOW;
            low_byte_reg     <= 8'h00;
            wr_ptr_reg       <= 2'd0;
            rd_ptr_reg       <= 2'd0;
            count_reg        <= 3'd0;
            issued_reg       <= 8'h00;
            result_reg       <= 8'h00;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= pop;
            if (pop) begin
                result_reg <= core_result;
                issued_reg <= issued_reg + 8'd1;
            end

            if (byte_accept) begin
                if (state_reg == LOW) begin
                    low_byte_reg <= in_byte;
                    state_reg    <= HIGH;
                end else begin
                    state_reg    <= LOW;
                end
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + 3'(push) - 3'(pop);

`ifdef ISSUE_BRANCH_FLUSH_EN
            // Later assignments win: a flush overrides any push/pop bookkeeping above.
            if (flush) begin
                wr_ptr_reg <= 2'd0;
                rd_ptr_reg <= 2'd0;
                count_reg  <= 3'd0;
                state_reg  <= LOW;
            end
`endif
        end
    end

    assign result_out   = result_reg;
    assign result_valid = result_valid_reg;
    assign fifo_count   = count_reg;
    assign issued_count = issued_reg;

endmodule

// File: tb/tb_riscv_mini_issue_ctrl.sv
// Directed self-checking bench for riscv_mini_issue_ctrl; expectations follow ISSUE_BRANCH_FLUSH_EN if defined.
module tb_riscv_mini_issue_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] issue_instr;
    logic        issue_valid;
    logic        issue_ready;
    logic [7:0]  core_result;
    logic [7:0]  result_out;
    logic        result_valid;
    logic [2:0]  fifo_count;
    logic [7:0]  issued_count;

    int errors = 0;
    int checks = 0;

    riscv_mini_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .issue_instr  (issue_instr),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .core_result  (core_result),
        .result_out   (result_out),
        .result_valid (result_valid),
        .fifo_count   (fifo_count),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push_instr(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic pop_one(input logic [7:0] res);
        issue_ready = 1'b1;
        core_result = res;
        step();
        issue_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_q [4];

        rst         = 1'b1;
        in_byte     = 8'h00;
        in_valid    = 1'b0;
        issue_ready = 1'b0;
        core_result = 8'h00;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_issued_count", 32'(issued_count), 32'h0);
        chk("rst_result_out", 32'(result_out), 32'h0);
        chk("rst_result_valid", 32'(result_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Assemble one instruction from two bytes.
        push_instr(16'h114C);
        chk("first_count", 32'(fifo_count), 32'h1);
        chk("first_instr", 32'(issue_instr), 32'h114C);
        chk("first_issue_valid", 32'(issue_valid), 32'h1);
        $display("txn push 114C count=%0d", fifo_count);

        pop_one(8'h05);
        chk("pop_result_out", 32'(result_out), 32'h05);
        chk("pop_result_valid", 32'(result_valid), 32'h1);
        chk("pop_issued", 32'(issued_count), 32'h1);
        chk("pop_count", 32'(fifo_count), 32'h0);
        chk("pop_issue_valid", 32'(issue_valid), 32'h0);
        step();
        chk("pulse_end", 32'(result_valid), 32'h0);
        chk("result_hold", 32'(result_out), 32'h05);
        $display("txn pop result=%0h issued=%0d", result_out, issued_count);

        // Fill to full with no issue; write pointer wraps on the fourth push.
        exp_q[0] = 16'h2201;
        exp_q[1] = 16'h3302;
        exp_q[2] = 16'h4400;
        exp_q[3] = 16'h5501;
        for (int i = 0; i < 4; i++) push_instr(exp_q[i]);
        chk("full_count", 32'(fifo_count), 32'h4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_head", 32'(issue_instr), 32'h2201);
        send_byte(8'hEE);
        chk("full_no_accept", 32'(fifo_count), 32'h4);
        chk("full_head_hold", 32'(issue_instr), 32'h2201);
        $display("txn fill count=%0d", fifo_count);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(issue_instr), 32'(exp_q[i]));
            pop_one(8'(8'h10 + i));
            chk("drain_result", 32'(result_out), 32'(8'h10 + i));
            $display("txn drain %0d count=%0d", i, fifo_count);
        end
        chk("drain_count", 32'(fifo_count), 32'h0);
        chk("drain_issued", 32'(issued_count), 32'h5);

        // High-byte push coincides with a pop at occupancy 2.
        push_instr(16'h6601);
        push_instr(16'h7702);
        chk("pp_pre_count", 32'(fifo_count), 32'h2);
        send_byte(8'h03);
        in_valid    = 1'b1;
        in_byte     = 8'h88;
        issue_ready = 1'b1;
        core_result = 8'h22;
        step();
        in_valid    = 1'b0;
        issue_ready = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'h2);
        chk("pp_head", 32'(issue_instr), 32'h7702);
        chk("pp_issued", 32'(issued_count), 32'h6);
        $display("txn push+pop count=%0d", fifo_count);
        pop_one(8'h00);
        chk("pp_new_entry", 32'(issue_instr), 32'h8803);
        pop_one(8'h00);
        chk("pp_drain_count", 32'(fifo_count), 32'h0);
        chk("pp_drain_issued", 32'(issued_count), 32'h8);

        // Branch at head, not taken.
        push_instr(16'h1003);
        push_instr(16'h2201);
        push_instr(16'h3302);
        push_instr(16'h4400);
        chk("br_head", 32'(issue_instr), 32'h1003);
        pop_one(8'h00);
        chk("br_nt_count", 32'(fifo_count), 32'h3);
        chk("br_nt_head", 32'(issue_instr), 32'h2201);
        chk("br_nt_issued", 32'(issued_count), 32'h9);
        $display("txn branch not-taken count=%0d", fifo_count);
        for (int i = 0; i < 3; i++) pop_one(8'h00);
        chk("br_nt_drain", 32'(fifo_count), 32'h0);

        // Branch at head, taken.
        push_instr(16'h1003);
        push_instr(16'h2201);
        push_instr(16'h3302);
        push_instr(16'h4400);
        pop_one(8'h01);
        chk("br_t_result", 32'(result_out), 32'h01);
        chk("br_t_valid", 32'(result_valid), 32'h1);
        chk("br_t_issued", 32'(issued_count), 32'd13);
`ifdef ISSUE_BRANCH_FLUSH_EN
        chk("br_t_count", 32'(fifo_count), 32'h0);
        chk("br_t_issue_valid", 32'(issue_valid), 32'h0);
`else
        chk("br_t_count", 32'(fifo_count), 32'h3);
        chk("br_t_head", 32'(issue_instr), 32'h2201);
        for (int i = 0; i < 3; i++) pop_one(8'h00);
`endif
        $display("txn branch taken count=%0d", fifo_count);
        push_instr(16'hA5B6);
        chk("after_br_count", 32'(fifo_count), 32'h1);
        chk("after_br_head", 32'(issue_instr), 32'hA5B6);
        pop_one(8'h3C);
        chk("after_br_result", 32'(result_out), 32'h3C);
`ifdef ISSUE_BRANCH_FLUSH_EN
        chk("after_br_issued", 32'(issued_count), 32'd14);
`else
        chk("after_br_issued", 32'(issued_count), 32'd17);
`endif

        // Reset mid-assembly discards the pending low byte.
        send_byte(8'h4C);
        rst = 1'b1;
        step();
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        chk("mid_rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("mid_rst_issued", 32'(issued_count), 32'h0);
        chk("mid_rst_result", 32'(result_out), 32'h0);
        rst = 1'b0;
        push_instr(16'h114C);
        chk("mid_rst_count", 32'(fifo_count), 32'h1);
        chk("mid_rst_head", 32'(issue_instr), 32'h114C);
        $display("txn reset mid-assembly head=%0h", issue_instr);
        pop_one(8'h77);
        chk("final_issued", 32'(issued_count), 32'h1);
        chk("final_count", 32'(fifo_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
